// File: rtl/map_sst_seq.sv
// Save-state sequencer: copies 128 mapper registers to the shared state buffer (save) or back (load).
// Optional read-back check after each load write is enabled with the SST_VERIFY_EN macro.
module map_sst_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       sav_start,
  input  logic       lod_start,
  output logic       busy,
  output logic       done,
  output logic       sst_act,
  output logic       sst_we_reg,
  output logic [7:0] sst_addr,
  output logic [7:0] sst_dato,
  input  logic [7:0] sst_di,
  output logic       buf_req,
  output logic       buf_we,
  output logic [7:0] buf_addr,
  output logic [7:0] buf_do,
  input  logic [7:0] buf_di,
  input  logic       buf_ack,
  output logic       vfy_err
);

  localparam int unsigned IDX_W = 7;
  localparam int unsigned DAT_W = 8;
  localparam int unsigned ADR_W = 8;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(127);

  typedef enum logic [2:0] {IDLE, S_RD, S_WR, L_RD, L_WR, L_CHK, DONE} state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [DAT_W-1:0]   data, data_n;
  logic               active_n;
  logic               busy_n, done_n, sst_we_n, buf_req_n, buf_we_n;
  logic [ADR_W-1:0]   sst_addr_n, buf_addr_n;
  logic [DAT_W-1:0]   sst_dato_n, buf_do_n;
`ifdef SST_VERIFY_EN
  logic               vfy_n;
`endif

  // Next state plus next value of every registered output, derived from the next state
  always_comb begin
    state_n = state;
    idx_n   = idx;
    data_n  = data;
`ifdef SST_VERIFY_EN
    vfy_n   = vfy_err;
`endif
    case (state)
      IDLE: begin
        if (sav_start) begin
          state_n = S_RD;
          idx_n   = '0;
        end else if (lod_start) begin
          state_n = L_RD;
          idx_n   = '0;
`ifdef SST_VERIFY_EN
          vfy_n   = 1'b0;
`endif
        end
      end
      S_RD: begin
        data_n  = sst_di;
        state_n = S_WR;
      end
      S_WR: begin
        if (buf_ack) begin
          if (idx == IDX_LAST) state_n = DONE;
          else begin
            idx_n   = idx + IDX_W'(1);
            state_n = S_RD;
          end
        end
      end
      L_RD: begin
        if (buf_ack) begin
          data_n  = buf_di;
          state_n = L_WR;
        end
      end
      L_WR: state_n = L_CHK;
      L_CHK: begin
`ifdef SST_VERIFY_EN
        if (sst_di != data) vfy_n = 1'b1;
`endif
        if (idx == IDX_LAST) state_n = DONE;
        else begin
          idx_n   = idx + IDX_W'(1);
          state_n = L_RD;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    active_n   = (state_n != IDLE) && (state_n != DONE);
    busy_n     = active_n;
    done_n     = (state_n == DONE);
    sst_addr_n = active_n ? {1'b0, idx_n} : '0;
    sst_we_n   = (state_n == L_WR);
    sst_dato_n = (state_n == L_WR) ? data_n : sst_dato;
    buf_req_n  = (state_n == S_WR) || (state_n == L_RD);
    buf_we_n   = (state_n == S_WR);
    buf_addr_n = buf_req_n ? {1'b0, idx_n} : '0;
    buf_do_n   = buf_we_n ? data_n : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      data       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sst_we_reg <= 1'b0;
      sst_addr   <= '0;
      sst_dato   <= '0;
      buf_req    <= 1'b0;
      buf_we     <= 1'b0;
      buf_addr   <= '0;
      buf_do     <= '0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      data       <= data_n;
      busy       <= busy_n;
      done       <= done_n;
      sst_we_reg <= sst_we_n;
      sst_addr   <= sst_addr_n;
      sst_dato   <= sst_dato_n;
      buf_req    <= buf_req_n;
      buf_we     <= buf_we_n;
      buf_addr   <= buf_addr_n;
      buf_do     <= buf_do_n;
    end
  end

  // Mapper access is active exactly while the sequence is busy
  assign sst_act = busy;

`ifdef SST_VERIFY_EN
  always_ff @(posedge clk) begin
    if (rst) vfy_err <= 1'b0;
    else     vfy_err <= vfy_n;
  end
`else
  assign vfy_err = 1'b0;
`endif

endmodule

// File: tb/tb_map_sst_seq.sv
// Directed/randomized bench for map_sst_seq with mapper and state-buffer models.
module tb_map_sst_seq;

  logic       clk = 1'b0;
  logic       rst, sav_start, lod_start;
  logic       busy, done, sst_act, sst_we_reg, buf_req, buf_we, buf_ack, vfy_err;
  logic [7:0] sst_addr, sst_dato, sst_di, buf_addr, buf_do, buf_di;

`ifdef SST_VERIFY_EN
  localparam logic VFY = 1'b1;
`else
  localparam logic VFY = 1'b0;
`endif

  map_sst_seq dut (
    .clk(clk), .rst(rst), .sav_start(sav_start), .lod_start(lod_start),
    .busy(busy), .done(done), .sst_act(sst_act), .sst_we_reg(sst_we_reg),
    .sst_addr(sst_addr), .sst_dato(sst_dato), .sst_di(sst_di),
    .buf_req(buf_req), .buf_we(buf_we), .buf_addr(buf_addr), .buf_do(buf_do),
    .buf_di(buf_di), .buf_ack(buf_ack), .vfy_err(vfy_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Environment: mapper register file and shared state buffer
  logic [7:0] map_regs [128];
  logic [7:0] buf_mem  [256];
  logic [7:0] map_init [128];
  logic [7:0] buf_init [256];
  logic       fill_map = 1'b0, fill_buf = 1'b0, corrupt_en = 1'b0;
  int         ack_dly = 0;
  int         wait_cnt = 0;

  assign buf_ack = buf_req && (wait_cnt >= ack_dly);
  assign buf_di  = buf_mem[buf_addr];
  assign sst_di  = map_regs[sst_addr[6:0]];

  always @(posedge clk) begin
    if (buf_req && !buf_ack) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;
    if (fill_buf) for (int i = 0; i < 256; i++) buf_mem[i] <= buf_init[i];
    else if (buf_req && buf_ack && buf_we) buf_mem[buf_addr] <= buf_do;
    if (fill_map) for (int i = 0; i < 128; i++) map_regs[i] <= map_init[i];
    else if (sst_we_reg)
      map_regs[sst_addr[6:0]] <= (corrupt_en && sst_addr == 8'd0 && sst_dato == 8'h03) ? 8'h01 : sst_dato;
  end

  // Observers: pulse counts and buffer-request stability
  int done_cnt = 0, we_cnt = 0, we_long = 0, req_cnt = 0, stab_viol = 0, we_mark = 0;
  logic [7:0] first_we_addr = 8'hFF, first_we_dat = 8'hFF;
  logic prev_we = 1'b0, prev_req = 1'b0, prev_ack = 1'b0, prev_bwe = 1'b0;
  logic [7:0] prev_addr = '0, prev_do = '0;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (sst_we_reg === 1'b1) begin
      if (we_cnt == we_mark) begin
        first_we_addr = sst_addr;
        first_we_dat  = sst_dato;
      end
      if (prev_we) we_long++;
      we_cnt++;
    end
    if (buf_req === 1'b1) req_cnt++;
    if (prev_req && !prev_ack &&
        (buf_req !== 1'b1 || buf_addr !== prev_addr || buf_we !== prev_bwe || buf_do !== prev_do))
      stab_viol++;
    prev_we = sst_we_reg; prev_req = buf_req; prev_ack = buf_ack;
    prev_bwe = buf_we; prev_addr = buf_addr; prev_do = buf_do;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic s, input logic l);
    @(negedge clk); sav_start = s; lod_start = l;
    @(posedge clk);
    @(negedge clk); sav_start = 1'b0; lod_start = 1'b0;
  endtask

  // Observe at each negedge until done; cyc counts posedges, the start-sampling edge being 1
  task automatic wait_done(input int cyc0, input int limit, output int cyc, output int busy_bad);
    cyc = cyc0; busy_bad = 0;
    while (done !== 1'b1 && cyc < limit) begin
      if (busy !== 1'b1) busy_bad++;
      @(negedge clk); cyc++;
    end
    if (done !== 1'b1) cyc = -1;
  endtask

  task automatic randomize_map(input logic [7:0] r0, input logic [7:0] r127);
    for (int i = 0; i < 128; i++) map_init[i] = 8'($urandom);
    map_init[0] = r0; map_init[127] = r127;
    @(negedge clk); fill_map = 1'b1;
    @(negedge clk); fill_map = 1'b0;
  endtask

  task automatic randomize_buf(input logic [7:0] b0);
    for (int i = 0; i < 256; i++) buf_init[i] = 8'($urandom);
    buf_init[0] = b0;
    @(negedge clk); fill_buf = 1'b1;
    @(negedge clk); fill_buf = 1'b0;
  endtask

  int cyc, bb, d0, w0, r0, bad;

  initial begin
    rst = 1'b1; sav_start = 1'b0; lod_start = 1'b0;
    randomize_map(8'h03, 8'hB9);
    randomize_buf(8'h55);
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);         check("rst_done", done, 0);
    check("rst_act", sst_act, 0);       check("rst_we", sst_we_reg, 0);
    check("rst_saddr", sst_addr, 0);    check("rst_dato", sst_dato, 0);
    check("rst_req", buf_req, 0);       check("rst_bwe", buf_we, 0);
    check("rst_baddr", buf_addr, 0);    check("rst_bdo", buf_do, 0);
    check("rst_vfy", vfy_err, 0);
    rst = 1'b0;

    // Save, zero-wait buffer
    ack_dly = 0; d0 = done_cnt; w0 = we_cnt;
    pulse_start(1'b1, 1'b0);
    wait_done(1, 5000, cyc, bb);
    check("save_cycles", cyc, 257);
    check("save_busy_hold", bb, 0);
    check("save_busy_at_done", busy, 0);
    check("save_act_at_done", sst_act, 0);
    check("save_buf0", buf_mem[0], 8'h03);
    check("save_buf127", buf_mem[127], 8'hB9);
    bad = 0;
    for (int i = 0; i < 128; i++) if (buf_mem[i] !== map_init[i]) bad++;
    check("save_buf_all", bad, 0);
    @(negedge clk);
    check("save_done_pulses", done_cnt - d0, 1);
    check("save_no_we", we_cnt - w0, 0);

    // Load with ack delayed 3 cycles
    randomize_buf(8'h02);
    ack_dly = 3; w0 = we_cnt; we_mark = we_cnt;
    pulse_start(1'b0, 1'b1);
    wait_done(1, 5000, cyc, bb);
    check("load_cycles", cyc, 128 * 6 + 1);
    check("load_busy_hold", bb, 0);
    check("load_first_we_addr", first_we_addr, 8'h00);
    check("load_first_we_dat", first_we_dat, 8'h02);
    check("load_we_pulses", we_cnt - w0, 128);
    check("load_we_one_cycle", we_long, 0);
    check("load_req_stable", stab_viol, 0);
    check("load_vfy_clean", vfy_err, 0);
    bad = 0;
    for (int i = 0; i < 128; i++) if (map_regs[i] !== buf_init[i]) bad++;
    check("load_map_all", bad, 0);

    // Save with 1-cycle ack delay
    randomize_map(8'($urandom), 8'($urandom));
    ack_dly = 1;
    pulse_start(1'b1, 1'b0);
    wait_done(1, 5000, cyc, bb);
    check("save_d1_cycles", cyc, 128 * 3 + 1);
    check("save_d1_req_stable", stab_viol, 0);
    bad = 0;
    for (int i = 0; i < 128; i++) if (buf_mem[i] !== map_init[i]) bad++;
    check("save_d1_buf_all", bad, 0);

    // Simultaneous starts pick save
    randomize_map(8'($urandom), 8'($urandom));
    ack_dly = 0; w0 = we_cnt;
    pulse_start(1'b1, 1'b1);
    wait_done(1, 5000, cyc, bb);
    check("both_cycles", cyc, 257);
    check("both_no_we", we_cnt - w0, 0);
    bad = 0;
    for (int i = 0; i < 128; i++) if (buf_mem[i] !== map_init[i]) bad++;
    check("both_buf_all", bad, 0);

    // lod_start mid-save is ignored
    randomize_map(8'($urandom), 8'($urandom));
    w0 = we_cnt;
    pulse_start(1'b1, 1'b0);
    repeat (20) @(negedge clk);
    check("mid_idx10", sst_addr, 10);
    lod_start = 1'b1;
    @(negedge clk); lod_start = 1'b0;
    d0 = done_cnt;
    wait_done(22, 5000, cyc, bb);
    check("mid_cycles", cyc, 257);
    @(negedge clk);
    check("mid_done_pulses", done_cnt - d0, 1);
    check("mid_no_we", we_cnt - w0, 0);
    bad = 0;
    for (int i = 0; i < 128; i++) if (buf_mem[i] !== map_init[i]) bad++;
    check("mid_buf_all", bad, 0);

    // Reset during load at idx 40
    randomize_buf(8'($urandom));
    pulse_start(1'b0, 1'b1);
    repeat (120) @(negedge clk);
    check("abort_idx40", sst_addr, 40);
    check("abort_req_before", buf_req, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);       check("abort_act", sst_act, 0);
    check("abort_done", done, 0);       check("abort_we", sst_we_reg, 0);
    check("abort_req", buf_req, 0);     check("abort_saddr", sst_addr, 0);
    check("abort_baddr", buf_addr, 0);  check("abort_dato", sst_dato, 0);
    d0 = done_cnt; w0 = we_cnt; r0 = req_cnt;
    repeat (10) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_no_we", we_cnt - w0, 0);
    check("abort_no_req", req_cnt - r0, 0);

    // Load with a mapper that corrupts reg0
    randomize_buf(8'h03);
    corrupt_en = 1'b1;
    pulse_start(1'b0, 1'b1);
    wait_done(1, 5000, cyc, bb);
    check("vfy_cycles", cyc, 385);
    check("vfy_at_done", vfy_err, VFY);
    @(negedge clk);
    check("vfy_held", vfy_err, VFY);
    corrupt_en = 1'b0;
    pulse_start(1'b0, 1'b1);
    check("vfy_clear_on_load", vfy_err, 0);
    wait_done(1, 5000, cyc, bb);
    check("vfy_clean_load", vfy_err, 0);
    check("vfy_reg0_fixed", map_regs[0], 8'h03);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/map_sst_seq.md
MAP_SST_SEQ -- requirements
Module: map_sst_seq

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  synchronous active-high reset.
REQ-003 SHALL have port sav_start  input  1  one-cycle pulse; begin save (mapper regs -> buffer).
REQ-004 SHALL have port lod_start  input  1  one-cycle pulse; begin load (buffer -> mapper regs).
REQ-005 SHALL have port busy  output  1  high from the cycle after an accepted start until the DONE state.
REQ-006 SHALL have port done  output  1  one-cycle pulse on sequence completion.
REQ-007 SHALL have port sst_act  output  1  save-state access active toward the mapper.
REQ-008 SHALL have port sst_we_reg  output  1  one-cycle mapper register write strobe.
REQ-009 SHALL have port sst_addr  output  8  mapper register index, range 0..127.
REQ-010 SHALL have port sst_dato  output  8  data written to the mapper register.
REQ-011 SHALL have port sst_di  input  8  mapper register readback, valid one cycle after sst_addr.
REQ-012 SHALL have ports buf_req/buf_we (output 1 each), buf_addr (output 8), buf_do (output 8), buf_di (input 8), buf_ack (input 1): request/ack port to the shared state buffer.
REQ-013 SHALL have port vfy_err  output  1  sticky load-verify mismatch flag (present only with SST_VERIFY_EN).

Function
REQ-014 SHALL implement states IDLE, S_RD, S_WR, L_RD, L_WR, L_CHK, DONE, plus a 7-bit index idx.
REQ-015 SHALL in IDLE accept sav_start -> S_RD or lod_start -> L_RD with idx=0; simultaneous starts SHALL select save.
REQ-016 SHALL ignore sav_start/lod_start while busy.
REQ-017 SHALL drive sst_act=1 in every state except IDLE and DONE; sst_addr={1'b0,idx}.
REQ-018 SHALL in S_RD hold for exactly one cycle, then capture sst_di into a data register and enter S_WR.
REQ-019 SHALL in S_WR assert buf_req=1, buf_we=1, buf_addr={1'b0,idx}, buf_do=captured data, and hold all of them stable until buf_ack.
REQ-020 SHALL on buf_ack in S_WR go to DONE if idx==127, else increment idx and go to S_RD.
REQ-021 SHALL in L_RD assert buf_req=1, buf_we=0, buf_addr={1'b0,idx}; on buf_ack capture buf_di and go to L_WR.
REQ-022 SHALL in L_WR pulse sst_we_reg for exactly one cycle with sst_dato=captured data, then go to L_CHK.
REQ-023 SHALL in L_CHK spend one cycle (compare slot), then go to DONE if idx==127, else increment idx and go to L_RD.
REQ-024 SHALL treat buf_ack outside a requesting state as a no-op.
REQ-025 SHALL in DONE pulse done=1 for one cycle, drop sst_act, and return to IDLE.
REQ-026 SHALL with zero-wait ack complete a save in 257 cycles after the start cycle (2 per register + DONE), and a load in 385 (3 per register + DONE).
REQ-027 SHALL never assert sst_we_reg during a save.

Reset
REQ-028 SHALL on rst force IDLE, idx=0, busy=0, done=0, sst_act=0, sst_we_reg=0, buf_req=0, buf_we=0, sst_addr=0, sst_dato=0, buf_addr=0, buf_do=0, vfy_err=0.
REQ-029 SHALL abort a sequence mid-operation when rst is asserted, with no further buffer request or mapper strobe issued.

Configuration
REQ-030 SHALL with SST_VERIFY_EN defined compare sst_di against the written data in L_CHK and set vfy_err on mismatch; vfy_err SHALL clear only on rst or on an accepted lod_start.
REQ-031 SHALL without SST_VERIFY_EN tie vfy_err to 0 and still keep the one-cycle L_CHK state so that timing is identical.

Verification
REQ-032 SHALL cover save with a zero-wait buffer: reg0 readback 0x03, reg127 readback 0xB9 -> buffer writes addr0=0x03, addr127=0xB9; done 257 cycles after sav_start.
REQ-033 SHALL cover load with buf_ack delayed 3 cycles: buffer addr0=0x02 -> one sst_we_reg pulse at sst_addr=0 with sst_dato=0x02; buf_addr/buf_req stay stable during the wait.
REQ-034 SHALL cover sav_start and lod_start in the same cycle -> save sequence runs and sst_we_reg stays 0 throughout.
REQ-035 SHALL cover rst asserted at idx=40 of a load -> next cycle IDLE, all outputs at reset values, no done pulse.
REQ-036 SHALL cover, with SST_VERIFY_EN, a mapper that returns 0x01 after 0x03 is written to reg0 -> vfy_err=1 after that L_CHK and held through done.
REQ-037 SHALL cover lod_start pulsed mid-save at idx=10 -> ignored; save completes normally with a single done pulse.
